// File: rtl/halo_partials_receiver_if.sv
// Bus bundle between the halo receiver, the eight neighbor senders and the banked output buffer.
// The slave view belongs to the receiver; the master view belongs to whoever drives neighbors and owns the buffer.
interface halo_partials_receiver_if #(
   parameter int BANK_COUNT = 32,
   parameter int TILE_SIZE  = 128
);
   localparam int RC_W = $clog2(TILE_SIZE);
   localparam int BK_W = $clog2(BANK_COUNT);

   logic [7:0][7:0]      neighbor_input_value;
   logic [7:0][RC_W-1:0] neighbor_input_row;
   logic [7:0][RC_W-1:0] neighbor_input_column;
   logic [7:0]           neighbor_input_write_enable;
   logic [7:0]           neighbor_exchange_done;
   logic [7:0]           neighbor_cts;

   logic [BK_W-1:0]      buffer_bank_read;
   logic [RC_W-1:0]      buffer_bank_entry;
   logic [7:0]           buffer_data_read;
   logic                 buffer_write_enable;
   logic [BK_W-1:0]      buffer_bank_write;
   logic [RC_W-1:0]      buffer_bank_entry_write;
   logic [7:0]           buffer_data_write;

   modport slave (
      input  neighbor_input_value, neighbor_input_row, neighbor_input_column,
      input  neighbor_input_write_enable, neighbor_exchange_done,
      output neighbor_cts,
      output buffer_bank_read, buffer_bank_entry,
      input  buffer_data_read,
      output buffer_write_enable, buffer_bank_write, buffer_bank_entry_write, buffer_data_write
   );

   modport master (
      output neighbor_input_value, neighbor_input_row, neighbor_input_column,
      output neighbor_input_write_enable, neighbor_exchange_done,
      input  neighbor_cts,
      input  buffer_bank_read, buffer_bank_entry,
      output buffer_data_read,
      input  buffer_write_enable, buffer_bank_write, buffer_bank_entry_write, buffer_data_write
   );
endinterface

// File: rtl/halo_partials_receiver.sv
// Queues neighbor halo partial sums per neighbor and read-modify-write accumulates them (saturating) into
// the banked output buffer, one per cycle: read in the pop cycle, write the next; done once all neighbors finish.
module halo_partials_receiver #(
   parameter int BANK_COUNT = 32,
   parameter int TILE_SIZE  = 128,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               bitwidth,
   input  logic                     exchange_start,
   halo_partials_receiver_if.slave  bus,
   output logic                     accumulate_done,
   output logic                     overflow_error
);
   localparam int RC_W  = $clog2(TILE_SIZE);
   localparam int BK_W  = $clog2(BANK_COUNT);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [7:0]      value;
      logic [RC_W-1:0] row;
      logic [RC_W-1:0] col;
   } item_t;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   state_t           state_q, state_d;
   logic [7:0]       done_seen_q, done_seen_d;
   item_t            mem_q [8][FIFO_DEPTH];
   item_t            mem_d [8][FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q [8];
   logic [PTR_W-1:0] rd_ptr_d [8];
   logic [PTR_W-1:0] wr_ptr_q [8];
   logic [PTR_W-1:0] wr_ptr_d [8];
   logic [CNT_W-1:0] cnt_q [8];
   logic [CNT_W-1:0] cnt_d [8];
   logic [2:0]       rr_ptr_q, rr_ptr_d;
   logic             s1_vld_q, s1_vld_d;
   logic [BK_W-1:0]  s1_bank_q, s1_bank_d;
   logic [RC_W-1:0]  s1_entry_q, s1_entry_d;
   logic [7:0]       s1_sum_q, s1_sum_d;
   logic             err_q, err_d;

   logic             win_vld;
   logic [2:0]       win_idx;
   item_t            head;
   logic [BK_W-1:0]  rd_bank;
   logic [RC_W-1:0]  rd_entry;
   logic [7:0]       operand;
   logic [7:0]       push_vec;
   logic [7:0]       pop_vec;
   logic [7:0]       cts;
   logic             active;
   logic             queues_empty;

   function automatic logic [BK_W-1:0] map_bank(input logic [RC_W-1:0] row, input logic [RC_W-1:0] col,
                                                input logic [1:0] bw);
      logic [31:0] ru, rs, sh;
      ru = 32'(row) >> bw;
      rs = 32'(row) & ((32'd1 << bw) - 32'd1);
      sh = (ru * 32'd3) % 32'(BANK_COUNT);
      return BK_W'((32'(col) + sh + rs * (32'(BANK_COUNT) >> bw)) % 32'(BANK_COUNT));
   endfunction

   function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Overflow shows up as the carry disagreeing with the sign bit.
   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {a[7], a} + {b[7], b};
      if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7f;
      return s[7:0];
   endfunction

   assign active = (state_q == ACCUM) || (state_q == DRAIN);

   always_comb begin
      state_d     = state_q;
      done_seen_d = done_seen_q;
      case (state_q)
         IDLE, DONE: begin
            if (exchange_start) begin
               state_d     = ACCUM;
               done_seen_d = '0;
            end
         end
         ACCUM: begin
            done_seen_d = done_seen_q | bus.neighbor_exchange_done;
            if (&done_seen_d) state_d = DRAIN;
         end
         DRAIN: begin
            if (queues_empty && !s1_vld_q && (push_vec == '0)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_d      = mem_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      cnt_d      = cnt_q;
      rr_ptr_d   = rr_ptr_q;
      err_d      = err_q;
      s1_vld_d   = 1'b0;
      s1_bank_d  = s1_bank_q;
      s1_entry_d = s1_entry_q;
      s1_sum_d   = s1_sum_q;
      win_vld    = 1'b0;
      win_idx    = '0;
      push_vec   = '0;
      pop_vec    = '0;
      cts        = '0;
      queues_empty = 1'b1;

      for (int i = 0; i < 8; i++) begin
         if (!win_vld && (cnt_q[3'(rr_ptr_q + 3'(i))] != '0)) begin
            win_vld = 1'b1;
            win_idx = 3'(rr_ptr_q + 3'(i));
         end
         if (cnt_q[i] != '0) queues_empty = 1'b0;
      end

      head     = mem_q[win_idx][rd_ptr_q[win_idx]];
      rd_bank  = map_bank(head.row, head.col, bitwidth);
      rd_entry = head.row >> bitwidth;
      // Back-to-back hits on one location must see the sum still waiting to be written.
      operand  = (s1_vld_q && (s1_bank_q == rd_bank) && (s1_entry_q == rd_entry)) ? s1_sum_q
                                                                                  : bus.buffer_data_read;
      if (win_vld) begin
         s1_vld_d   = 1'b1;
         s1_bank_d  = rd_bank;
         s1_entry_d = rd_entry;
         s1_sum_d   = sat_add(head.value, operand);
         rr_ptr_d   = win_idx + 3'd1;
         pop_vec[win_idx] = 1'b1;
      end

      for (int k = 0; k < 8; k++) begin
         if (bus.neighbor_input_write_enable[k]) begin
            if (active && (cnt_q[k] != CNT_W'(FIFO_DEPTH))) begin
               push_vec[k] = 1'b1;
               mem_d[k][wr_ptr_q[k]] = {bus.neighbor_input_value[k], bus.neighbor_input_row[k],
                                        bus.neighbor_input_column[k]};
               wr_ptr_d[k] = inc_ptr(wr_ptr_q[k]);
            end else begin
               err_d = 1'b1;
            end
         end
         if (pop_vec[k]) rd_ptr_d[k] = inc_ptr(rd_ptr_q[k]);
         cnt_d[k] = cnt_q[k] + CNT_W'(push_vec[k]) - CNT_W'(pop_vec[k]);
         // Senders launch one cycle after seeing cts, so leave room for a write already on the wire.
         cts[k] = (state_q == ACCUM) &&
                  (({1'b0, cnt_q[k]} + (CNT_W+1)'(bus.neighbor_input_write_enable[k])) <=
                   (CNT_W+1)'(FIFO_DEPTH - 2));
      end

      bus.neighbor_cts      = cts;
      bus.buffer_bank_read  = win_vld ? rd_bank : '0;
      bus.buffer_bank_entry = win_vld ? rd_entry : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         done_seen_q <= '0;
         rr_ptr_q    <= '0;
         s1_vld_q    <= 1'b0;
         s1_bank_q   <= '0;
         s1_entry_q  <= '0;
         s1_sum_q    <= '0;
         err_q       <= 1'b0;
         for (int k = 0; k < 8; k++) begin
            rd_ptr_q[k] <= '0;
            wr_ptr_q[k] <= '0;
            cnt_q[k]    <= '0;
            for (int d = 0; d < FIFO_DEPTH; d++) mem_q[k][d] <= '0;
         end
      end else begin
         state_q     <= state_d;
         done_seen_q <= done_seen_d;
         rr_ptr_q    <= rr_ptr_d;
         s1_vld_q    <= s1_vld_d;
         s1_bank_q   <= s1_bank_d;
         s1_entry_q  <= s1_entry_d;
         s1_sum_q    <= s1_sum_d;
         err_q       <= err_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         mem_q       <= mem_d;
      end
   end

   assign bus.buffer_write_enable     = s1_vld_q;
   assign bus.buffer_bank_write       = s1_bank_q;
   assign bus.buffer_bank_entry_write = s1_entry_q;
   assign bus.buffer_data_write       = s1_sum_q;
   assign accumulate_done             = (state_q == DONE);
   assign overflow_error              = err_q;
endmodule
